sc_demap: RTL and testbench
===========================

Name: sc_demap

Overview:
- Subcarrier demapper for the 802.16 OFDM receive path, placed directly downstream of the 256-point FFT stage.
- Accepts FFT bins in natural order (index 0 = DC, 1..127 = positive, 128..255 = negative) over a Wishbone-style slave port.
- Discards guard bands and DC, and reorders the 200 used subcarriers into ascending frequency order (-100..-1, +1..+100).
- Emits them on a Wishbone-style master port with pilot and end-of-symbol tags.

Parameters:
- DW, 32: sample width; Im in [31:16], Re in [15:0], format 5.11, passed through untouched.
- NFFT, 256: FFT size; counters are log2(NFFT) bits.
- NHALF, 100: used subcarriers per side; depth of each buffer bank.

Ports:
- CLK_I  in  1  clock
- RST_I  in  1  asynchronous reset, active-low
- DAT_I  in  DW  FFT bin
- WE_I, STB_I, CYC_I  in  1  slave strobes
- ACK_O  out  1  input sample accepted this cycle
- DAT_O  out  DW  reordered subcarrier
- PILOT_O  out  1  DAT_O is a pilot (±13, ±38, ±63, ±88)
- LAST_O  out  1  DAT_O is the last subcarrier of the symbol
- CYC_O, STB_O, WE_O  out  1  master strobes; WE_O = STB_O
- ACK_I  in  1  downstream accepted DAT_O

Behaviour:
- **Reset:** DAT_O = 0, STB_O = CYC_O = PILOT_O = LAST_O = 0, ACK_O = 0. Both banks free, input index = 0, FSM = S_WAIT.
- **Input handshake:** a sample is accepted when CYC_I & STB_I & WE_I & ACK_O. ACK_O is combinational and depends on the current index:
  - Index 0, 101..155: always acknowledged, data discarded.
  - Index 1..100: acknowledged only if the write bank is free. The sample is written to write-bank address idx-1.
  - Index 156..255: acknowledged only if FSM = S_NEG and the output register is free (~STB_O | ACK_I). The sample is loaded into DAT_O and STB_O = 1 on the next edge (1-cycle latency).
- **Index counter:** increments on every accepted sample and wraps 255 -> 0. After index 100 is written, the write bank is marked busy and the write pointer toggles to the other bank.
- **Output FSM:**
  - S_WAIT -> S_NEG when a bank is busy (positives held).
  - S_NEG: forwards negative bins -100..-1. Goes to S_POS after the bin-255 handshake.
  - S_POS: reads the oldest busy bank at addresses 0..99 (+1..+100). Sustains 1 output per cycle while ACK_I = 1. The first STB_O occurs within 2 cycles of entering S_POS. LAST_O is asserted with +100.
  - After the +100 handshake, the bank is freed and the FSM goes to S_WAIT.
- **Output register:** STB_O and DAT_O/PILOT_O/LAST_O hold until ACK_I. A new load happens only when ~STB_O | ACK_I.
- **CYC_O:** set on the first STB_O. Cleared when the FSM is in S_WAIT, STB_O = 0, no bank is busy and CYC_I = 0.
- **Pilot flag:** derived from the logical subcarrier number.
- **Back-to-back symbols:** the next symbol's positives fill the other bank while the current bank drains. If both banks are busy, index 1 of the next symbol stalls (ACK_O = 0).
- **CYC_I deasserted mid-symbol:**
  - Index resets to 0.
  - A partially written bank is discarded (stays free).
  - If in S_NEG, the FSM returns to S_WAIT and frees that symbol's bank.
  - Any DAT_O already presented completes its handshake.
  - A bank already draining in S_POS finishes.
- **Simultaneous events:** a bank free and a new write to the same bank in the same cycle gives free-then-write; the write is permitted.
- **Reset mid-operation:** takes effect immediately; all state is cleared and buffered data is lost.

Optional Feature:
- SC_DEMAP_DROP_PILOT_EN
  - **Defined:** pilot bins are acknowledged and discarded, never presented; 192 outputs per symbol; PILOT_O tied 0; LAST_O still on +100.
  - **Undefined:** 200 outputs per symbol, with pilots flagged on PILOT_O.

Decomposition:
- **Package ofdm_sc_pkg:**
  - NFFT, NHALF, DC index 0.
  - Negative start index 156.
  - Pilot position constant list (±13, ±38, ±63, ±88).
  - FSM state encodings.
- **Sub-module sc_bank_ram:** 2 x NHALF x DW simple dual-port RAM. One write port (bank, addr), one registered read port (bank, addr).

Test Plan:
- **Single symbol:** DAT_I = index 0..255, ACK_I = 1 -> 200 outputs, values 156..255 then 1..100. PILOT_O on values 168, 193, 218, 243, 13, 38, 63, 88. LAST_O only on 100.
- **Backpressure:** ACK_I pseudo-random at 50% -> identical sequence, no drop or duplicate, DAT_O stable while STB_O & ~ACK_I.
- **Streaming:** 4 symbols back-to-back with ACK_I = 1 -> 800 outputs in order. Count ACK_O-low cycles for timing, no loss.
- **Both banks busy:** ACK_I = 0 for 600 cycles during symbol 2 -> ACK_O = 0 at symbol 3 index 1 until a bank frees.
- **CYC_I drop:** drop at index 120 of symbol 1, then send a full symbol 2 -> only symbol 2 output, 200 words.
- **Reset:** assert RST_I mid S_POS at output +40 -> all outputs 0 the same cycle. The next full symbol is reproduced correctly. Rerun scenario 1 with SC_DEMAP_DROP_PILOT_EN -> 192 outputs, no pilot values.

Source files
------------

// File: rtl/ofdm_sc_pkg.sv
// Shared constants for the 802.16 OFDM subcarrier demapper: FFT geometry,
// natural-order bin landmarks, pilot positions and the output FSM encoding.
package ofdm_sc_pkg;

    localparam int SC_NFFT      = 256;
    localparam int SC_NHALF     = 100;
    localparam int SC_DC_IDX    = 0;
    localparam int SC_NEG_START = SC_NFFT - SC_NHALF;   // bin 156 = subcarrier -100

    // Pilot subcarriers sit at +/- these magnitudes
    localparam int SC_NPILOT = 4;
    localparam int SC_PILOT_MAG [SC_NPILOT] = '{13, 38, 63, 88};

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_NEG  = 2'd1,
        S_POS  = 2'd2
    } sc_state_e;

    // True when |subcarrier| is a pilot position
    function automatic logic sc_is_pilot(input int mag);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < SC_NPILOT; i++) begin
            if (mag == SC_PILOT_MAG[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/sc_bank_ram.sv
// Two-bank simple dual-port RAM holding the positive subcarriers of up to
// two symbols. One write port, one registered read port with read enable
// so the read data holds while the consumer stalls.
module sc_bank_ram #(
    parameter int DW    = 32,
    parameter int DEPTH = 100,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic          wbank_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic          rbank_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2][DEPTH];
    logic [DW-1:0] rdata_q;

    // Write port and registered read port; contents need no reset
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[wbank_i][waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[rbank_i][raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sc_demap.sv
// Subcarrier demapper: takes natural-order FFT bins, drops DC and guard
// bands, and emits the 200 used subcarriers in ascending frequency order
// (-100..-1, +1..+100). Positives are parked in a two-bank buffer while the
// negatives of the same symbol stream straight through.
// Build option: define SC_DEMAP_DROP_PILOT_EN to swallow pilot bins
// (192 outputs per symbol, PILOT_O stays 0).
module sc_demap
    import ofdm_sc_pkg::*;
#(
    parameter int DW    = 32,
    parameter int NFFT  = SC_NFFT,
    parameter int NHALF = SC_NHALF
) (
    input  logic          CLK_I,
    input  logic          RST_I,
    input  logic [DW-1:0] DAT_I,
    input  logic          WE_I,
    input  logic          STB_I,
    input  logic          CYC_I,
    output logic          ACK_O,
    output logic [DW-1:0] DAT_O,
    output logic          PILOT_O,
    output logic          LAST_O,
    output logic          CYC_O,
    output logic          STB_O,
    output logic          WE_O,
    input  logic          ACK_I
);

`ifdef SC_DEMAP_DROP_PILOT_EN
    localparam bit DROP_PILOT = 1'b1;
`else
    localparam bit DROP_PILOT = 1'b0;
`endif

    localparam int IW = $clog2(NFFT);
    localparam int AW = $clog2(NHALF);
    localparam int RW = $clog2(NHALF + 1);
    localparam logic [IW-1:0] IDX_DC      = IW'(SC_DC_IDX);
    localparam logic [IW-1:0] IDX_POS_END = IW'(NHALF);
    localparam logic [IW-1:0] IDX_NEG0    = IW'(NFFT - NHALF);
    localparam logic [IW-1:0] IDX_MAX     = IW'(NFFT - 1);
    localparam logic [RW-1:0] RA_END      = RW'(NHALF);
    localparam logic [AW-1:0] RA_LAST     = AW'(NHALF - 1);

    // Control state
    logic [IW-1:0] idx_q, idx_d;
    logic          wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [1:0]    busy_q, busy_d;
    sc_state_e     state_q, state_d;
    logic [RW-1:0] ra_q, ra_d;
    logic [AW-1:0] rtag_q, rtag_d;
    logic          rvalid_q, rvalid_d;
    // Output register
    logic [DW-1:0] dat_q, dat_d;
    logic          stb_q, stb_d, pilot_q, pilot_d, last_q, last_d, cyc_q, cyc_d;

    logic          in_pos, in_neg, neg_pilot, neg_skip, load_ok, out_hs, pos_done;
    logic          wr_free, ack_ok, acc, drop_free;
    logic          ram_re, pos_skip, pos_load, neg_load;
    logic [DW-1:0] ram_rdata;

    sc_bank_ram #(.DW(DW), .DEPTH(NHALF), .AW(AW)) u_ram (
        .clk_i   (CLK_I),
        .we_i    (acc && in_pos),
        .wbank_i (wr_bank_q),
        .waddr_i (AW'(idx_q - 1'b1)),
        .wdata_i (DAT_I),
        .re_i    (ram_re),
        .rbank_i (rd_bank_q),
        .raddr_i (AW'(ra_q)),
        .rdata_o (ram_rdata)
    );

    // Bin classification and the combinational input acknowledge
    always_comb begin
        in_pos    = (idx_q != IDX_DC) && (idx_q <= IDX_POS_END);
        in_neg    = (idx_q >= IDX_NEG0);
        neg_pilot = in_neg && sc_is_pilot(NFFT - int'(idx_q));
        neg_skip  = DROP_PILOT && neg_pilot;
        load_ok   = !stb_q || ACK_I;
        out_hs    = stb_q && ACK_I;
        pos_done  = (state_q == S_POS) && out_hs && last_q;
        // A bank released this cycle may be refilled in the same cycle
        wr_free   = !busy_q[wr_bank_q] || (pos_done && (rd_bank_q == wr_bank_q));
        if (in_pos)      ack_ok = wr_free;
        else if (in_neg) ack_ok = (state_q == S_NEG) && (neg_skip || load_ok);
        else             ack_ok = 1'b1;
        acc       = CYC_I && STB_I && WE_I && ack_ok;
        // Aborted symbol whose positives were already committed to a bank
        drop_free = !CYC_I && (idx_q > IDX_POS_END);
    end

    // Index counter, bank bookkeeping and output FSM next state
    always_comb begin
        idx_d     = idx_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        busy_d    = busy_q;
        state_d   = state_q;
        if (!CYC_I)   idx_d = '0;
        else if (acc) idx_d = idx_q + 1'b1;
        if (pos_done) begin
            busy_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end
        // The aborted symbol's bank is the newest one; hand it back to the writer
        if (drop_free) begin
            busy_d[~wr_bank_q] = 1'b0;
            wr_bank_d          = ~wr_bank_q;
        end
        if (acc && (idx_q == IDX_POS_END)) begin
            busy_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
        end
        case (state_q)
            S_WAIT:  if ((busy_q != 2'b00) && !drop_free) state_d = S_NEG;
            S_NEG: begin
                if (!CYC_I)                             state_d = S_WAIT;
                else if (acc && (idx_q == IDX_MAX))     state_d = S_POS;
            end
            S_POS:   if (pos_done) state_d = S_WAIT;
            default: state_d = S_WAIT;
        endcase
    end

    // Bank read sequencing and output register loading
    always_comb begin
        ram_re   = (state_q == S_POS) && (ra_q < RA_END) && (!rvalid_q || load_ok);
        pos_skip = DROP_PILOT && sc_is_pilot(int'(ra_q) + 1);
        pos_load = (state_q == S_POS) && rvalid_q && load_ok;
        neg_load = acc && in_neg && !neg_skip;
        ra_d     = ra_q;
        rtag_d   = rtag_q;
        rvalid_d = rvalid_q && !load_ok;
        if (ram_re) begin
            ra_d     = ra_q + 1'b1;
            rtag_d   = AW'(ra_q);
            rvalid_d = !pos_skip;
        end
        if (pos_done) ra_d = '0;

        dat_d   = dat_q;
        stb_d   = stb_q;
        pilot_d = pilot_q;
        last_d  = last_q;
        cyc_d   = cyc_q;
        if (neg_load) begin
            dat_d   = DAT_I;
            stb_d   = 1'b1;
            pilot_d = neg_pilot;
            last_d  = 1'b0;
        end else if (pos_load) begin
            dat_d   = ram_rdata;
            stb_d   = 1'b1;
            pilot_d = sc_is_pilot(int'(rtag_q) + 1);
            last_d  = (rtag_q == RA_LAST);
        end else if (out_hs) begin
            stb_d   = 1'b0;
            pilot_d = 1'b0;
            last_d  = 1'b0;
        end
        if (stb_d) cyc_d = 1'b1;
        else if ((state_q == S_WAIT) && !stb_q && (busy_q == 2'b00) && !CYC_I) cyc_d = 1'b0;
    end

    // Control registers
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            idx_q     <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            busy_q    <= 2'b00;
            state_q   <= S_WAIT;
            ra_q      <= '0;
            rtag_q    <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            busy_q    <= busy_d;
            state_q   <= state_d;
            ra_q      <= ra_d;
            rtag_q    <= rtag_d;
            rvalid_q  <= rvalid_d;
        end
    end

    // Output register: holds until downstream acknowledges
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            dat_q   <= '0;
            stb_q   <= 1'b0;
            pilot_q <= 1'b0;
            last_q  <= 1'b0;
            cyc_q   <= 1'b0;
        end else begin
            dat_q   <= dat_d;
            stb_q   <= stb_d;
            pilot_q <= pilot_d;
            last_q  <= last_d;
            cyc_q   <= cyc_d;
        end
    end

    assign ACK_O   = acc;
    assign DAT_O   = dat_q;
    assign STB_O   = stb_q;
    assign WE_O    = stb_q;
    assign CYC_O   = cyc_q;
    assign PILOT_O = pilot_q;
    assign LAST_O  = last_q;

endmodule

// File: tb/tb_sc_demap.sv
// Scoreboard bench for sc_demap: each full symbol pushes its expected
// reordered outputs; the monitor pops and compares on every output handshake.
module tb_sc_demap;

`ifdef SC_DEMAP_DROP_PILOT_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif
    localparam int NOUT = DROP ? 192 : 200;

    typedef struct packed {
        logic [31:0] dat;
        logic        pilot;
        logic        last;
    } exp_t;

    logic        CLK_I = 1'b0;
    logic        RST_I = 1'b0;
    logic [31:0] DAT_I = '0;
    logic        WE_I = 1'b0, STB_I = 1'b0, CYC_I = 1'b0;
    logic        ACK_O;
    logic [31:0] DAT_O;
    logic        PILOT_O, LAST_O, CYC_O, STB_O, WE_O;
    logic        ACK_I = 1'b1;

    exp_t exp_q[$];
    int   n_tests = 0, n_fail = 0;
    int   rcv_cnt = 0, stall_cnt = 0, ack_mode = 0;

    sc_demap dut (
        .CLK_I   (CLK_I),
        .RST_I   (RST_I),
        .DAT_I   (DAT_I),
        .WE_I    (WE_I),
        .STB_I   (STB_I),
        .CYC_I   (CYC_I),
        .ACK_O   (ACK_O),
        .DAT_O   (DAT_O),
        .PILOT_O (PILOT_O),
        .LAST_O  (LAST_O),
        .CYC_O   (CYC_O),
        .STB_O   (STB_O),
        .WE_O    (WE_O),
        .ACK_I   (ACK_I)
    );

    always #5 CLK_I = ~CLK_I;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic is_pil(input int mag);
        return (mag == 13) || (mag == 38) || (mag == 63) || (mag == 88);
    endfunction

    function automatic logic [31:0] mk(input int sym, input int i);
        logic [15:0] s, b;
        s = 16'(sym);
        b = 16'(i);
        return {s, b};
    endfunction

    task automatic push_symbol(input int sym);
        exp_t e;
        for (int i = 156; i < 256; i++) begin
            if (!(DROP && is_pil(256 - i))) begin
                e.dat = mk(sym, i); e.pilot = !DROP && is_pil(256 - i); e.last = 1'b0;
                exp_q.push_back(e);
            end
        end
        for (int i = 1; i <= 100; i++) begin
            if (!(DROP && is_pil(i))) begin
                e.dat = mk(sym, i); e.pilot = !DROP && is_pil(i); e.last = (i == 100);
                exp_q.push_back(e);
            end
        end
    endtask

    // Drive bins 0..255; drop_at >= 0 releases CYC_I at that bin instead
    task automatic send_symbol(input int sym, input int drop_at);
        int wait_n;
        if (drop_at < 0) push_symbol(sym);
        for (int i = 0; i < 256; i++) begin
            if (i == drop_at) begin
                CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
                return;
            end
            DAT_I = mk(sym, i); CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1;
            wait_n = 0;
            forever begin
                @(negedge CLK_I);
                if (ACK_O) break;
                stall_cnt++;
                wait_n++;
                if (wait_n > 3000) begin
                    check("ack_timeout", ACK_O, 1);
                    STB_I = 1'b0; WE_I = 1'b0;
                    return;
                end
            end
            @(posedge CLK_I); #1;
        end
        STB_I = 1'b0; WE_I = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int nexp);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20000) begin
            @(posedge CLK_I); #2;
            n++;
        end
        repeat (4) @(posedge CLK_I);
        #2;
        check({tag, "_left"}, exp_q.size(), 0);
        check({tag, "_count"}, rcv_cnt, nexp);
    endtask

    // Downstream acknowledge: always, random 50%, or held off
    initial begin
        forever begin
            @(posedge CLK_I); #1;
            case (ack_mode)
                0:       ACK_I = 1'b1;
                1:       ACK_I = 1'($urandom_range(0, 1));
                default: ACK_I = 1'b0;
            endcase
        end
    end

    // Output monitor and scoreboard compare
    initial begin
        logic [31:0] held;
        logic        hold_v;
        exp_t        e;
        hold_v = 1'b0;
        held   = '0;
        forever begin
            @(negedge CLK_I);
            if (!RST_I) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v) check("hold", DAT_O, held);
                hold_v = STB_O && !ACK_I;
                held   = DAT_O;
                if (STB_O && ACK_I) begin
                    rcv_cnt++;
                    if (exp_q.size() == 0) begin
                        check("extra", STB_O, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("dat", DAT_O, e.dat);
                        check("pilot", PILOT_O, e.pilot);
                        check("last", LAST_O, e.last);
                        check("cyc", CYC_O, 1);
                    end
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int target, n;
        // Reset state
        repeat (3) @(posedge CLK_I);
        #1;
        check("rst_dat", DAT_O, 0);
        check("rst_stb", STB_O, 0);
        check("rst_we", WE_O, 0);
        check("rst_cyc", CYC_O, 0);
        check("rst_pilot", PILOT_O, 0);
        check("rst_last", LAST_O, 0);
        check("rst_ack", ACK_O, 0);
        RST_I = 1'b1;
        @(posedge CLK_I); #1;

        // Single symbol, downstream always ready
        rcv_cnt = 0;
        send_symbol(1, -1);
        CYC_I = 1'b0;
        wait_drain("single", NOUT);
        check("cyc_idle", CYC_O, 0);

        // Random backpressure
        ack_mode = 1;
        rcv_cnt  = 0;
        send_symbol(2, -1);
        CYC_I = 1'b0;
        wait_drain("bp", NOUT);
        ack_mode = 0;

        // Four symbols back to back
        rcv_cnt   = 0;
        stall_cnt = 0;
        for (int s = 10; s < 14; s++) send_symbol(s, -1);
        CYC_I = 1'b0;
        wait_drain("stream", 4 * NOUT);
        $display("info: stream ACK_O low cycles = %0d", stall_cnt);

        // Long downstream stall while one bank drains and the next fills
        rcv_cnt   = 0;
        stall_cnt = 0;
        fork
            begin
                send_symbol(20, -1);
                send_symbol(21, -1);
                send_symbol(22, -1);
            end
            begin
                repeat (300) @(posedge CLK_I);
                #1 ack_mode = 2;
                repeat (600) @(posedge CLK_I);
                #1 ack_mode = 0;
            end
        join
        CYC_I = 1'b0;
        check("stall_seen", (stall_cnt >= 400), 1);
        wait_drain("stall", 3 * NOUT);

        // CYC_I dropped at bin 120, then a complete symbol
        rcv_cnt = 0;
        send_symbol(30, 120);
        repeat (5) @(posedge CLK_I);
        #1;
        send_symbol(31, -1);
        CYC_I = 1'b0;
        wait_drain("drop", NOUT);

        // Reset while draining positives, around output +40
        rcv_cnt = 0;
        send_symbol(40, -1);
        CYC_I  = 1'b0;
        target = (NOUT / 2) + 40;
        n = 0;
        while (rcv_cnt < target && n < 5000) begin
            @(negedge CLK_I); #1;
            n++;
        end
        check("rst_reach", rcv_cnt, target);
        RST_I = 1'b0;
        #1;
        check("mid_rst_dat", DAT_O, 0);
        check("mid_rst_stb", STB_O, 0);
        check("mid_rst_cyc", CYC_O, 0);
        check("mid_rst_last", LAST_O, 0);
        check("mid_rst_pilot", PILOT_O, 0);
        exp_q.delete();
        repeat (3) @(posedge CLK_I);
        #1 RST_I = 1'b1;
        @(posedge CLK_I); #1;
        rcv_cnt = 0;
        send_symbol(41, -1);
        CYC_I = 1'b0;
        wait_drain("after_rst", NOUT);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
